// File: rtl/mode_select_ctrl.sv
// rtl/mode_select_ctrl.sv - debounced next/prev/load buttons stepping a registered 3-bit mode code
// Buttons and switches are synchronised, debounced per button, and edge-detected into one-cycle presses.
module mode_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2_500_000,
  parameter bit SKIP_EXTRA      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_load,
  input  logic [2:0] sw_mode,
  output logic [2:0] mode_select,
  output logic       mode_changed
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam int B_NEXT = 0;
  localparam int B_PREV = 1;
  localparam int B_LOAD = 2;

  logic [2:0]    btn_raw;
  logic [2:0]    btn_s1_q, btn_s2_q;
  logic [2:0]    sw_s1_q, sw_s2_q;
  logic [2:0]    db_q, db_dly_q;
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    press;
  logic [2:0]    mode_q, mode_d;
  logic          changed_q;

  assign btn_raw = {btn_load, btn_prev, btn_next};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_mode;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_dly_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (btn_s2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_q[i]  <= btn_s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  assign press = db_q & ~db_dly_q;

  always_comb begin
    mode_d = mode_q;
    if (press[B_LOAD]) begin
      mode_d = (SKIP_EXTRA && sw_s2_q == 3'd4) ? 3'd0 : sw_s2_q;
    end else if (press[B_NEXT]) begin
      mode_d = mode_q + 3'd1;
      if (SKIP_EXTRA && mode_d == 3'd4) mode_d = 3'd5;
    end else if (press[B_PREV]) begin
      mode_d = mode_q - 3'd1;
      if (SKIP_EXTRA && mode_d == 3'd4) mode_d = 3'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= 3'd0;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      changed_q <= (mode_d != mode_q);
    end
  end

  assign mode_select  = mode_q;
  assign mode_changed = changed_q;

endmodule

// File: tb/tb_mode_select_ctrl.sv
// tb/tb_mode_select_ctrl.sv - directed and random checks of mode_select_ctrl against a window-based reference
module tb_mode_select_ctrl;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_load = 1'b0;
  logic [2:0] sw_mode = 3'd0;
  logic [2:0] mode1, mode0;
  logic       chg1, chg0;

  always #5 clk = ~clk;

  mode_select_ctrl #(.DEBOUNCE_CYCLES(DC), .SKIP_EXTRA(1'b1)) u_dut_skip (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .btn_load(btn_load),
    .sw_mode(sw_mode), .mode_select(mode1), .mode_changed(chg1)
  );

  mode_select_ctrl #(.DEBOUNCE_CYCLES(DC), .SKIP_EXTRA(1'b0)) u_dut_noskip (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev), .btn_load(btn_load),
    .sw_mode(sw_mode), .mode_select(mode0), .mode_changed(chg0)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: raw samples kept in a sliding window; a button's level flips when the
  // last DC synchronised samples all disagree with it. Index 0 is the oldest sample.
  logic [2:0] bq[$];
  logic [2:0] sq[$];
  logic [2:0] m_db, m_pend;
  int         m_mode[2];
  int         m_chg[2];
  int         edge_cnt, first_step, str1, str0;

  function automatic int step(input int m, input int dir, input bit skip);
    int r;
    r = (m + dir + 8) % 8;
    if (skip && r == 4) r = 4 + dir;
    return r;
  endfunction

  task automatic model_reset;
    bq.delete();
    sq.delete();
    for (int i = 0; i < DC + 2; i++) begin
      bq.push_back(3'd0);
      sq.push_back(3'd0);
    end
    m_db       = '0;
    m_pend     = '0;
    m_mode[0]  = 0;
    m_mode[1]  = 0;
    m_chg[0]   = 0;
    m_chg[1]   = 0;
    edge_cnt   = 0;
    first_step = -1;
  endtask

  task automatic model_edge;
    logic [2:0] new_db, v, swv;
    int         nw;
    bit         all;
    bit         skip;
    bq.push_back({btn_load, btn_prev, btn_next});
    sq.push_back(sw_mode);
    while (bq.size() > DC + 2) begin
      void'(bq.pop_front());
      void'(sq.pop_front());
    end
    swv = sq[DC-1];
    for (int k = 0; k < 2; k++) begin
      skip = (k == 0);
      nw = m_mode[k];
      if (m_pend[2]) nw = (skip && swv == 3'd4) ? 0 : int'(swv);
      else if (m_pend[0]) nw = step(m_mode[k], 1, skip);
      else if (m_pend[1]) nw = step(m_mode[k], -1, skip);
      m_chg[k]  = (nw != m_mode[k]) ? 1 : 0;
      m_mode[k] = nw;
    end
    new_db = m_db;
    for (int b = 0; b < 3; b++) begin
      all = 1'b1;
      for (int i = 0; i < DC; i++) begin
        v = bq[i];
        if (v[b] == m_db[b]) all = 1'b0;
      end
      if (all) new_db[b] = ~m_db[b];
    end
    m_pend = new_db & ~m_db;
    m_db   = new_db;
    edge_cnt++;
  endtask

  task automatic tick;
    @(posedge clk);
    model_edge();
    #1;
    check("mode_skip", mode1, m_mode[0]);
    check("chg_skip", chg1, m_chg[0]);
    check("mode_noskip", mode0, m_mode[1]);
    check("chg_noskip", chg0, m_chg[1]);
    if (chg1) str1++;
    if (chg0) str0++;
    if (first_step < 0 && mode1 != 3'd0) first_step = edge_cnt;
  endtask

  task automatic do_reset;
    #2 reset = 1'b1;
    #1;
    check("rst_async_mode", mode1, 0);
    check("rst_async_chg", chg1, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic press(input logic [2:0] m, input int hold, input int gap);
    {btn_load, btn_prev, btn_next} = m;
    repeat (hold) tick();
    {btn_load, btn_prev, btn_next} = 3'b000;
    repeat (gap) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_skip[7];
    seq_skip = '{1, 2, 3, 5, 6, 7, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_mode", mode1, 0);
    check("reset_chg", chg1, 0);
    reset = 1'b0;

    str1 = 0;
    press(3'b001, 10, 10);
    check("latency_edge", first_step, 3 + DC);
    check("latency_strobes", str1, 1);

    btn_next = 1'b1;
    repeat (3) tick();
    do_reset();
    repeat (12) tick();
    check("rst_held_edge", first_step, 3 + DC);
    btn_next = 1'b0;
    repeat (12) tick();
    check("rst_held_mode", mode1, 1);

    do_reset();
    str1 = 0;
    str0 = 0;
    for (int i = 0; i < 7; i++) begin
      press(3'b001, 10, 10);
      check("next_seq", mode1, seq_skip[i]);
      check("next_seq_noskip", mode0, i + 1);
    end
    check("next_strobes", str1, 7);
    check("next_strobes_noskip", str0, 7);
    press(3'b001, 10, 10);
    check("next_wrap_noskip", mode0, 0);

    do_reset();
    str1 = 0;
    for (int c = 0; c < 40; c++) begin
      btn_prev = ((c / 3) % 2 == 0);
      tick();
    end
    check("bounce_quiet", str1, 0);
    check("bounce_mode", mode1, 0);
    btn_prev = 1'b1;
    repeat (20) tick();
    btn_prev = 1'b0;
    repeat (10) tick();
    check("bounce_step", mode1, 7);
    check("bounce_strobes", str1, 1);

    sw_mode = 3'd6;
    repeat (3) tick();
    str1 = 0;
    press(3'b100, 10, 10);
    check("load6", mode1, 6);
    check("load6_strobe", str1, 1);
    press(3'b100, 10, 10);
    check("load6_again", mode1, 6);
    check("load6_again_strobe", str1, 1);
    sw_mode = 3'd4;
    repeat (3) tick();
    press(3'b100, 10, 10);
    check("load4_skip", mode1, 0);
    check("load4_strobe", str1, 2);
    check("load4_noskip", mode0, 4);

    sw_mode = 3'd5;
    press(3'b100, 10, 10);
    check("pre_simul", mode1, 5);
    sw_mode = 3'd2;
    repeat (3) tick();
    press(3'b101, 10, 10);
    check("simul_load_next", mode1, 2);
    sw_mode = 3'd3;
    press(3'b100, 10, 10);
    press(3'b011, 10, 10);
    check("simul_next_prev", mode1, 5);
    check("simul_next_prev_noskip", mode0, 4);

    for (int r = 0; r < 400; r++) begin
      {btn_load, btn_prev, btn_next} = 3'($urandom_range(0, 7));
      sw_mode = 3'($urandom);
      if ($urandom_range(0, 60) == 0) do_reset();
      repeat ($urandom_range(1, 9)) tick();
    end
    {btn_load, btn_prev, btn_next} = 3'b000;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
